// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width derivation and Gray/binary conversion,
// used by both the read-side and write-side pointer controllers.
package fifo_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] ptr_wide_t;

    // One extra bit beyond the address width serves as the lap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

    function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
        ptr_wide_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
            b[GRAY_MAX_W-1-i] = b[GRAY_MAX_W-i] ^ g[GRAY_MAX_W-1-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational Gray-to-binary converter: XOR prefix chain running from the MSB down.
module gray2bin_comb #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o          = '0;
        bin_o[WIDTH-1] = gray_i[WIDTH-1];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            bin_o[WIDTH-1-i] = bin_o[WIDTH-i] ^ gray_i[WIDTH-1-i];
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: read pointer, Gray pointer for the write domain,
// and registered empty / almost_empty / fill level from the synchronised write pointer.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter  int unsigned MEM_DEPTH     = 8,
    parameter  int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned PTR_W         = ptr_width(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             rd_inc,
    input  logic [PTR_W-1:0] sync_wr_ptr,
    output logic [PTR_W-2:0] rd_addr,
    output logic [PTR_W-1:0] rd_ptr_gray,
    output logic             empty,
    output logic             almost_empty,
    output logic [PTR_W-1:0] rd_level
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic [PTR_W-1:0] wr_bin;
    logic             empty_q, empty_d;
    logic             aempty_q, aempty_d;
    logic             rd_en;

    gray2bin_comb #(
        .WIDTH (PTR_W)
    ) u_wr_g2b (
        .gray_i (sync_wr_ptr),
        .bin_o  (wr_bin)
    );

    // Status is computed against the post-read pointer so the edge that consumes
    // the last word also raises empty, leaving no window for an extra read.
    always_comb begin
        rd_en     = rd_inc & ~empty_q;
        rd_ptr_d  = rd_ptr_q + {{(PTR_W-1){1'b0}}, rd_en};
        rd_gray_d = PTR_W'(bin2gray(ptr_wide_t'(rd_ptr_d)));
        empty_d   = (rd_gray_d == sync_wr_ptr);
        level_d   = wr_bin - rd_ptr_d;
        aempty_d  = (level_d <= PTR_W'(AEMPTY_THRESH));
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rd_ptr_q  <= '0;
            rd_gray_q <= '0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
            level_q   <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            rd_gray_q <= rd_gray_d;
            empty_q   <= empty_d;
            aempty_q  <= aempty_d;
            level_q   <= level_d;
        end
    end

    assign rd_addr      = rd_ptr_q[PTR_W-2:0];
    assign rd_ptr_gray  = rd_gray_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign rd_level     = level_q;

endmodule
